// File: rtl/miriscv_mdu_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_mdu_pkg
//  Types for the multiply/divide unit.
//  mdu_op_t    : M-extension operation, encoded as the instruction's funct3.
//  mdu_state_t : control states of the iterative datapath.
// -----------------------------------------------------------------------------
package miriscv_mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2,
      MDU_DONE = 2'd3
   } mdu_state_t;

endpackage : miriscv_mdu_pkg

// File: rtl/miriscv_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_pkg
//  Core-wide constants shared by the miriscv pipeline blocks.
//  XLEN : architectural register width (32 for RV32, 64 for RV64).
// -----------------------------------------------------------------------------
package miriscv_pkg;

   localparam int XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_mdu.sv
// -----------------------------------------------------------------------------
// miriscv_mdu
//  Iterative multiply/divide unit for the miriscv execute stage
//  (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Operands are converted to magnitudes on accept; the CALC state then runs
//  XLEN shift-add (multiply) or restoring (divide) steps on one 2*XLEN shift
//  register with one shared adder; FIX applies the sign and picks the result.
//  Divide-by-zero, signed overflow and (FAST_MUL=1) multiplies go straight to
//  DONE from the accept edge.
//
//  Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   mdu_req_i     request valid (held by the requester until ready)
//   mdu_op_i      operation, funct3 encoding
//   mdu_port_a_i  rs1 operand
//   mdu_port_b_i  rs2 operand
//   mdu_kill_i    flush: abandon any operation, no done pulse
//   mdu_ready_o   idle, a request is accepted this cycle
//   mdu_done_o    one-cycle result-valid pulse
//   mdu_result_o  registered result, held until the next done
// -----------------------------------------------------------------------------
module miriscv_mdu
   import miriscv_mdu_pkg::*;
#(
   parameter int XLEN     = miriscv_pkg::XLEN,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            mdu_req_i,
   input  logic [2:0]      mdu_op_i,
   input  logic [XLEN-1:0] mdu_port_a_i,
   input  logic [XLEN-1:0] mdu_port_b_i,
   input  logic            mdu_kill_i,
   output logic            mdu_ready_o,
   output logic            mdu_done_o,
   output logic [XLEN-1:0] mdu_result_o
);

   localparam int CW = $clog2(XLEN);

   // ---------------------------------------------------------------- registers
   mdu_state_t        state_q;
   logic [CW-1:0]     cnt_q;
   mdu_op_t           op_q;
   logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] sr_q;       // {hi, lo}: product, or {remainder, quotient}
   logic              res_neg_q;  // product / quotient must be negated
   logic              rem_neg_q;  // remainder must be negated
   logic              ready_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   // ------------------------------------------------------- accept-side decode
   mdu_op_t         op_in;
   logic            is_mul_in;
   logic            sign_a_in;
   logic            sign_b_in;
   logic            a_neg_in;
   logic            b_neg_in;
   logic [XLEN-1:0] a_mag_in;
   logic [XLEN-1:0] b_mag_in;
   logic            accept;
   logic            div0_in;
   logic            ovf_in;
   logic            early_in;
   logic [XLEN-1:0] early_res;
   logic [2*XLEN-1:0] fast_prod;

   assign op_in     = mdu_op_t'(mdu_op_i);
   assign is_mul_in = ~mdu_op_i[2];

   always_comb begin
      sign_a_in = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                  (op_in == MDU_DIV)  || (op_in == MDU_REM);
      sign_b_in = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
   end

   assign a_neg_in = sign_a_in & mdu_port_a_i[XLEN-1];
   assign b_neg_in = sign_b_in & mdu_port_b_i[XLEN-1];
   // -(-2^(XLEN-1)) wraps to 2^(XLEN-1), which is the correct unsigned magnitude.
   assign a_mag_in = a_neg_in ? -mdu_port_a_i : mdu_port_a_i;
   assign b_mag_in = b_neg_in ? -mdu_port_b_i : mdu_port_b_i;

   assign accept   = mdu_req_i && ready_q && !mdu_kill_i;
   assign div0_in  = !is_mul_in && (mdu_port_b_i == '0);
   assign ovf_in   = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                     (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (mdu_port_b_i == '1);
   assign early_in = div0_in || ovf_in || (FAST_MUL && is_mul_in);

   if (FAST_MUL) begin : g_fast_mul
      logic [2*XLEN-1:0] mag_prod;
      assign mag_prod  = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
      assign fast_prod = (a_neg_in ^ b_neg_in) ? -mag_prod : mag_prod;
   end else begin : g_no_fast_mul
      assign fast_prod = '0;
   end

   // funct3[1] separates REM* from DIV*, funct3[1:0]==0 is the low-half MUL.
   always_comb begin
      early_res = '0;
      if (div0_in) begin
         early_res = mdu_op_i[1] ? mdu_port_a_i : '1;
      end else if (ovf_in) begin
         early_res = mdu_op_i[1] ? '0 : mdu_port_a_i;
      end else if (mdu_op_i[1:0] == 2'b00) begin
         early_res = fast_prod[XLEN-1:0];
      end else begin
         early_res = fast_prod[2*XLEN-1:XLEN];
      end
   end

   // ---------------------------------------------------- shared iteration step
   logic [XLEN:0]     rem_sh;   // partial remainder shifted left by one quotient bit
   logic [XLEN+1:0]   add_x;
   logic [XLEN+1:0]   add_y;
   logic              add_cin;
   logic [XLEN+1:0]   add_res;
   logic              div_ge;
   logic [2*XLEN-1:0] sr_d;

   assign rem_sh = {sr_q[2*XLEN-1:XLEN], sr_q[XLEN-1]};

   always_comb begin
      if (op_q[2]) begin
         // rem_sh - divisor as rem_sh + ~divisor + 1; top bit set means it went negative
         add_x   = {1'b0, rem_sh};
         add_y   = ~{2'b00, opnd_q};
         add_cin = 1'b1;
      end else begin
         add_x   = {2'b00, sr_q[2*XLEN-1:XLEN]};
         add_y   = sr_q[0] ? {2'b00, opnd_q} : '0;
         add_cin = 1'b0;
      end
   end

   assign add_res = add_x + add_y + {{(XLEN+1){1'b0}}, add_cin};
   assign div_ge  = ~add_res[XLEN+1];

   always_comb begin
      if (op_q[2]) begin
         sr_d = {(div_ge ? add_res[XLEN-1:0] : rem_sh[XLEN-1:0]), sr_q[XLEN-2:0], div_ge};
      end else begin
         // carry of the partial-product add drops into the top bit as everything shifts right
         sr_d = {add_res[XLEN:0], sr_q[XLEN-1:1]};
      end
   end

   // ------------------------------------------------------- sign fix / select
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fix_res;

   assign prod_fix = res_neg_q ? -sr_q : sr_q;

   always_comb begin
      case (op_q)
         MDU_MUL:                         fix_res = prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:               fix_res = res_neg_q ? -sr_q[XLEN-1:0] : sr_q[XLEN-1:0];
         default:                         fix_res = rem_neg_q ? -sr_q[2*XLEN-1:XLEN]
                                                              : sr_q[2*XLEN-1:XLEN];
      endcase
   end

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= MDU_IDLE;
         cnt_q     <= '0;
         op_q      <= MDU_MUL;
         opnd_q    <= '0;
         sr_q      <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else if (mdu_kill_i) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            MDU_IDLE: begin
               if (accept) begin
                  op_q      <= op_in;
                  res_neg_q <= a_neg_in ^ b_neg_in;
                  rem_neg_q <= a_neg_in;
                  ready_q   <= 1'b0;
                  cnt_q     <= '0;
                  if (early_in) begin
                     result_q <= early_res;
                     done_q   <= 1'b1;
                     state_q  <= MDU_DONE;
                  end else begin
                     opnd_q  <= is_mul_in ? a_mag_in : b_mag_in;
                     sr_q    <= {{XLEN{1'b0}}, (is_mul_in ? b_mag_in : a_mag_in)};
                     state_q <= MDU_CALC;
                  end
               end
            end
            MDU_CALC: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) begin
                  cnt_q   <= '0;
                  state_q <= MDU_FIX;
               end
            end
            MDU_FIX: begin
               result_q <= fix_res;
               done_q   <= 1'b1;
               state_q  <= MDU_DONE;
            end
            MDU_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= MDU_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               done_q  <= 1'b0;
               state_q <= MDU_IDLE;
            end
         endcase
      end
   end

   assign mdu_ready_o  = ready_q;
   assign mdu_done_o   = done_q;
   assign mdu_result_o = result_q;

endmodule : miriscv_mdu

// File: tb/tb_miriscv_mdu.sv
// -----------------------------------------------------------------------------
// tb_miriscv_mdu
//  Two instances (FAST_MUL=0 and FAST_MUL=1) driven one after the other.
//  Expected results come from plain signed/unsigned arithmetic on 64-bit
//  integers; expected latency comes from the early-out rules.
// -----------------------------------------------------------------------------
module tb_miriscv_mdu;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic [2:0]  op    [2];
   logic [31:0] pa    [2];
   logic [31:0] pb    [2];
   logic        kill  [2];
   logic        ready [2];
   logic        done  [2];
   logic [31:0] res   [2];

   logic [31:0] last_exp [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      miriscv_mdu #(
         .XLEN     (XLEN),
         .FAST_MUL (gi == 1)
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .mdu_req_i    (req[gi]),
         .mdu_op_i     (op[gi]),
         .mdu_port_a_i (pa[gi]),
         .mdu_port_b_i (pb[gi]),
         .mdu_kill_i   (kill[gi]),
         .mdu_ready_o  (ready[gi]),
         .mdu_done_o   (done[gi]),
         .mdu_result_o (res[gi])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V M semantics from plain integer arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      int              ia, ib;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      r  = '0;
      case (f)
         3'd0: begin up = ua * ub;           r = up[31:0];  end
         3'd1: begin sp = sa * sb;           r = sp[63:32]; end
         3'd2: begin sp = sa * longint'(ub); r = sp[63:32]; end
         3'd3: begin up = ua * ub;           r = up[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = ia / ib;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = ia % ib;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input int k, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      bit early;
      early = (f[2] && b == 0) ||
              ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
              (k == 1 && !f[2]);
      return early ? 1 : XLEN + 2;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(15));
         default: return $urandom;
      endcase
   endfunction

   // One transaction; all sampling at posedge+#1. hold keeps req high and
   // scrambles the inputs while the operation runs.
   task automatic run_op(input int k, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input bit hold);
      int n;
      int explat;
      explat = ref_lat(k, f, a, b);
      n = 0;
      while (!ready[k] && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("ready_before_req", ready[k], 1'b1);
      req[k] = 1'b1; op[k] = f; pa[k] = a; pb[k] = b;
      @(posedge clk); #1;
      if (!hold) req[k] = 1'b0;
      op[k] = 3'($urandom); pa[k] = $urandom; pb[k] = $urandom;
      n = 1;
      while (!done[k] && n < 100) begin
         @(posedge clk); #1; n++;
         if (hold) begin
            op[k] = 3'($urandom); pa[k] = $urandom; pb[k] = $urandom;
         end
      end
      req[k] = 1'b0;
      check("latency", n, explat);
      check("result", res[k], expv);
      check("ready_in_done", ready[k], 1'b0);
      $display("[fast=%0d] op=%0d a=%08h b=%08h -> %08h exp=%08h lat=%0d", k, f, a, b,
               res[k], expv, n);
      last_exp[k] = expv;
      @(posedge clk); #1;
      check("done_pulse_width", done[k], 1'b0);
      check("ready_after_done", ready[k], 1'b1);
   endtask

   // Watch for a done pulse over a window; none is expected.
   task automatic expect_quiet(input int k, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done[k]) seen = 1'b1;
      end
      check(tag, seen, 1'b0);
   endtask

   task automatic kill_tests(input int k);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = 32'($urandom_range(1, 1000));
      req[k] = 1'b1; op[k] = 3'd5; pa[k] = a; pb[k] = b;
      @(posedge clk); #1;
      req[k] = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      kill[k] = 1'b1;
      @(posedge clk); #1;
      kill[k] = 1'b0;
      check("kill_ready", ready[k], 1'b1);
      check("kill_done", done[k], 1'b0);
      expect_quiet(k, "kill_no_done");
      check("kill_result_held", res[k], last_exp[k]);
      $display("[fast=%0d] kill mid-CALC: ready=%0d result=%08h", k, ready[k], res[k]);
      run_op(k, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      // kill and req together in IDLE: must not be accepted
      req[k] = 1'b1; kill[k] = 1'b1; op[k] = 3'd5; pa[k] = 32'd50; pb[k] = 32'd5;
      @(posedge clk); #1;
      req[k] = 1'b0; kill[k] = 1'b0;
      check("kill_req_ready", ready[k], 1'b1);
      expect_quiet(k, "kill_req_no_done");
      $display("[fast=%0d] kill+req in IDLE: ready=%0d result=%08h", k, ready[k], res[k]);
   endtask

   task automatic reset_test(input int k);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = 32'($urandom_range(1, 1000));
      run_op(k, 3'd4, a, b, ref_mdu(3'd4, a, b), 1'b1);
      a = $urandom;
      req[k] = 1'b1; op[k] = 3'd4; pa[k] = a; pb[k] = b;
      @(posedge clk); #1;
      repeat (10) begin
         op[k] = 3'($urandom); pa[k] = $urandom; pb[k] = $urandom;
         @(posedge clk); #1;
         check("no_spurious_done", done[k], 1'b0);
      end
      rst = 1'b1; req[k] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_ready", ready[k], 1'b1);
      check("rst_done", done[k], 1'b0);
      check("rst_result", res[k], 32'd0);
      last_exp[0] = '0; last_exp[1] = '0;
      expect_quiet(k, "rst_no_done");
      $display("[fast=%0d] reset mid-CALC: ready=%0d done=%0d result=%08h", k, ready[k],
               done[k], res[k]);
   endtask

   localparam int ND = 12;
   logic [2:0]  d_op  [ND] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a   [ND] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b   [ND] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd2, 32'd2,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_exp [ND] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; op[k] = '0; pa[k] = '0; pb[k] = '0; kill[k] = 1'b0;
         last_exp[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("reset_ready", ready[k], 1'b1);
         check("reset_done", done[k], 1'b0);
         check("reset_result", res[k], 32'd0);
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < ND; i++) run_op(k, d_op[i], d_a[i], d_b[i], d_exp[i], 1'b0);
         for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(7));
            a = pick();
            b = pick();
            run_op(k, f, a, b, ref_mdu(f, a, b), 1'b0);
         end
         kill_tests(k);
         reset_test(k);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_miriscv_mdu
